dma_burst_engine: RTL and testbench

// - Parametrised DMA controller: moves cmd_len blocks of BLOCK_WORDS words from the device (edata) into memory at cmd_addr.
// - Sits between the I/O device, the CPU bus arbiter (BR/BG) and memory; the CPU issues a command, the block writes memory and raises interrupt.
// - Adds over the earlier block: programmable base address/length, multi-block bursts, per-word data select, BG-drop pause/resume, command handshake.

---
 rtl/dma_pkg.sv | 14 +
 rtl/dma_xfer_counter.sv | 47 ++++
 rtl/dma_burst_engine.sv | 102 ++++++++++
 tb/tb_dma_burst_engine.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA burst engine: FSM state encoding and default geometry.
package dma_pkg;

  localparam int DMA_WORD_SIZE   = 16;
  localparam int DMA_BLOCK_WORDS = 4;
  localparam int DMA_LEN_W       = 8;

  typedef enum logic [1:0] {
    DMA_IDLE = 2'd0,
    DMA_XFER = 2'd1,
    DMA_DONE = 2'd2
  } dma_state_e;

endpackage : dma_pkg

// File: rtl/dma_xfer_counter.sv
// Address / word-offset / remaining-block counters for one DMA transfer.
// Loads on command acceptance, advances once per written word, flags the final word.
module dma_xfer_counter
  import dma_pkg::*;
#(
  parameter int  WORD_SIZE   = DMA_WORD_SIZE,
  parameter int  BLOCK_WORDS = DMA_BLOCK_WORDS,
  parameter int  LEN_W       = DMA_LEN_W,
  localparam int OFF_W       = $clog2(BLOCK_WORDS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load,
  input  logic [WORD_SIZE-1:0] load_addr,
  input  logic [LEN_W-1:0]     load_len,
  input  logic                 advance,
  output logic [WORD_SIZE-1:0] addr,
  output logic [OFF_W-1:0]     offset,
  output logic                 last_word
);

  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BLOCK_WORDS - 1);

  logic [LEN_W-1:0] blk_left;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr     <= '0;
      offset   <= '0;
      blk_left <= '0;
    end else if (load) begin
      addr     <= load_addr;
      offset   <= '0;
      blk_left <= load_len;
    end else if (advance) begin
      // addr and offset wrap naturally at their widths; BLOCK_WORDS is a power of two
      addr   <= addr + WORD_SIZE'(1);
      offset <= offset + OFF_W'(1);
      if (offset == OFF_LAST)
        blk_left <= blk_left - LEN_W'(1);
    end
  end

  assign last_word = (offset == OFF_LAST) && (blk_left == LEN_W'(1));

endmodule : dma_xfer_counter

// File: rtl/dma_burst_engine.sv
// DMA burst engine: requests the bus, copies cmd_len device blocks into memory
// starting at cmd_addr while BG is held, then pulses interrupt for one cycle.
module dma_burst_engine
  import dma_pkg::*;
#(
  parameter int  WORD_SIZE   = DMA_WORD_SIZE,
  parameter int  BLOCK_WORDS = DMA_BLOCK_WORDS,
  parameter int  LEN_W       = DMA_LEN_W,
  localparam int OFF_W       = $clog2(BLOCK_WORDS)
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [WORD_SIZE-1:0]             cmd_addr,
  input  logic [LEN_W-1:0]                 cmd_len,
  input  logic                             BG,
  input  logic [BLOCK_WORDS*WORD_SIZE-1:0] edata,
  output logic                             BR,
  output logic                             WRITE,
  output logic [WORD_SIZE-1:0]             addr,
  output logic [WORD_SIZE-1:0]             data,
  output logic [OFF_W-1:0]                 offset,
  output logic                             interrupt,
  output logic                             busy
);

  dma_state_e state;
  logic       accept;
  logic       last_word;

  assign accept    = (state == DMA_IDLE) && cmd_valid;
  assign cmd_ready = (state == DMA_IDLE);
  assign busy      = (state != DMA_IDLE);
  // BG arrives already qualified by the arbiter, so it strobes the write directly
  assign WRITE     = (state == DMA_XFER) && BG;

  dma_xfer_counter #(
    .WORD_SIZE   (WORD_SIZE),
    .BLOCK_WORDS (BLOCK_WORDS),
    .LEN_W       (LEN_W)
  ) u_counter (
    .CLK       (CLK),
    .RST       (RST),
    .load      (accept),
    .load_addr (cmd_addr),
    .load_len  (cmd_len),
    .advance   (WRITE),
    .addr      (addr),
    .offset    (offset),
    .last_word (last_word)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= DMA_IDLE;
      BR        <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      case (state)
        DMA_IDLE: begin
          interrupt <= 1'b0;
          if (cmd_valid) begin
            if (cmd_len != '0) begin
              state <= DMA_XFER;
              BR    <= 1'b1;
            end else begin
              state     <= DMA_DONE;
              interrupt <= 1'b1;
            end
          end
        end
        DMA_XFER: begin
          if (BG && last_word) begin
            state     <= DMA_DONE;
            BR        <= 1'b0;
            interrupt <= 1'b1;
          end
        end
        DMA_DONE: begin
          state     <= DMA_IDLE;
          interrupt <= 1'b0;
        end
        default: begin
          state     <= DMA_IDLE;
          BR        <= 1'b0;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    data = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      if (offset == OFF_W'(i))
        data = edata[i*WORD_SIZE +: WORD_SIZE];
    end
  end

endmodule : dma_burst_engine

// File: tb/tb_dma_burst_engine.sv
// Randomised scoreboard bench for dma_burst_engine: stimulus pushes the expected
// write stream and interrupt, an independent monitor pops and compares.
module tb_dma_burst_engine;

  localparam int WS = 16;
  localparam int BW = 4;
  localparam int LW = 8;
  localparam int OW = 2;

  logic             CLK = 1'b0;
  logic             RST;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WS-1:0]    cmd_addr;
  logic [LW-1:0]    cmd_len;
  logic             BG;
  logic [BW*WS-1:0] edata;
  logic             BR;
  logic             WRITE;
  logic [WS-1:0]    addr;
  logic [WS-1:0]    data;
  logic [OW-1:0]    offset;
  logic             interrupt;
  logic             busy;

  dma_burst_engine #(
    .WORD_SIZE   (WS),
    .BLOCK_WORDS (BW),
    .LEN_W       (LW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .BG        (BG),
    .edata     (edata),
    .BR        (BR),
    .WRITE     (WRITE),
    .addr      (addr),
    .data      (data),
    .offset    (offset),
    .interrupt (interrupt),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    logic [WS-1:0] a;
    logic [OW-1:0] o;
  } wr_t;

  wr_t  wq[$];
  int   pend_intr  = 0;
  int   intr_seen  = 0;
  int   intr_cyc   = 0;
  int   total      = 0;
  int   bad        = 0;
  logic prev_intr  = 1'b0;
  wr_t  mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every write and interrupt against the scoreboard
  always @(negedge CLK) begin
    if (!RST) begin
      if (WRITE) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0h expected no write (cycle %0d)", addr, cyc);
        end else begin
          mon_e = wq.pop_front();
          check("wr_addr", addr, mon_e.a);
          check("wr_offset", offset, mon_e.o);
          check("wr_data", data, edata[mon_e.o*WS +: WS]);
          check("wr_br_high", BR, 1);
        end
      end
      if (interrupt) begin
        check("intr_expected", pend_intr > 0, 1);
        check("intr_after_all_words", wq.size() == 0, 1);
        check("intr_br_low", BR, 0);
        check("intr_single_cycle", prev_intr, 0);
        if (pend_intr > 0) pend_intr--;
        intr_cyc = cyc;
        intr_seen++;
      end
    end
    prev_intr = interrupt;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: a command of len blocks writes len*BW consecutive addresses
  task automatic push_cmd(input logic [WS-1:0] a, input int len);
    for (int i = 0; i < len * BW; i++)
      wq.push_back('{a: a + WS'(i), o: OW'(i % BW)});
    pend_intr++;
  endtask

  // mode 0: BG held high, 1: random BG plus a stray command while busy, 2: grant drop
  task automatic run_cmd(input logic [WS-1:0] a, input int len, input int mode, input bit check_lat);
    int            acc_cyc;
    int            start_seen;
    int            k;
    logic [WS-1:0] exp_a;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_addr   = a;
    cmd_len    = LW'(len);
    BG         = 1'b1;
    push_cmd(a, len);
    start_seen = intr_seen;
    tick();
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("cmd_ready_busy", cmd_ready, 0);
    check("br_after_accept", BR, len != 0);
    k = 1;
    while (intr_seen == start_seen && k < 3000) begin
      case (mode)
        0:       BG = 1'b1;
        1:       BG = ($urandom_range(0, 9) < 7);
        default: BG = !(k >= 3 && k <= 5);
      endcase
      edata = {$urandom, $urandom};
      if (mode == 1 && k == 3) begin
        cmd_valid = 1'b1;
        cmd_addr  = ~a;
        cmd_len   = LW'(7);
      end else begin
        cmd_valid = 1'b0;
      end
      if (mode == 2 && k >= 3 && k <= 5) begin
        #1;
        exp_a = a + WS'(2);
        check("drop_write_low", WRITE, 0);
        check("drop_br_high", BR, 1);
        check("drop_addr_frozen", addr, exp_a);
        check("drop_offset_frozen", offset, 2);
      end
      tick();
      k++;
    end
    cmd_valid = 1'b0;
    if (k >= 3000) begin
      total++;
      bad++;
      $display("FAIL intr_timeout: got no interrupt expected one within 3000 cycles");
    end else if (check_lat) begin
      check("intr_latency", intr_cyc - acc_cyc, len * BW);
    end
    BG = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200us");
    $fatal(1);
  end

  initial begin
    RST       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    BG        = 1'b1;
    edata     = {$urandom, $urandom};
    tick();
    tick();
    check("rst_br", BR, 0);
    check("rst_write", WRITE, 0);
    check("rst_addr", addr, 0);
    check("rst_offset", offset, 0);
    check("rst_interrupt", interrupt, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    RST = 1'b0;
    tick();

    run_cmd(16'h01F4, 1, 0, 1);
    run_cmd(16'h0100, 3, 0, 1);
    run_cmd(16'h0200, 1, 2, 0);
    run_cmd(16'h0500, 0, 0, 1);
    run_cmd(16'hFFFE, 1, 0, 1);

    // Reset after the first word of a two-block transfer
    cmd_valid = 1'b1;
    cmd_addr  = 16'h0300;
    cmd_len   = LW'(2);
    push_cmd(16'h0300, 2);
    tick();
    cmd_valid = 1'b0;
    BG        = 1'b1;
    tick();
    BG  = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    wq.delete();
    pend_intr = 0;
    BG = 1'b1;
    #1;
    check("midrst_br", BR, 0);
    check("midrst_write", WRITE, 0);
    check("midrst_addr", addr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_interrupt", interrupt, 0);
    for (int i = 0; i < 4; i++) tick();

    run_cmd(16'h0600, 2, 1, 0);

    for (int i = 0; i < 12; i++)
      run_cmd(WS'($urandom), $urandom_range(0, 5), (i % 3 == 0) ? 0 : 1, (i % 3 == 0));

    for (int i = 0; i < 3; i++) tick();
    check("final_queue_empty", wq.size(), 0);
    check("final_no_pending_intr", pend_intr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dma_burst_engine
